// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit owning HI/LO for the E stage.
// Define MDU_MADD_EN to enable madd/maddu (ops 7/8); otherwise they are no-ops.
module mdu_core #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   rhi, rlo;
  logic          rwr;

  logic          is_mul, is_div, is_madd, is_sgn, start_eff, div0;
  logic [63:0]   prod, res;
  logic [31:0]   abs_a, abs_b, q_mag, r_mag, quot, rem;

  always_comb begin
    is_madd = 1'b0;
`ifdef MDU_MADD_EN
    is_madd = (MDUOp == 4'd7) || (MDUOp == 4'd8);
`endif
    is_mul    = (MDUOp == 4'd1) || (MDUOp == 4'd2) || is_madd;
    is_div    = (MDUOp == 4'd3) || (MDUOp == 4'd4);
    is_sgn    = (MDUOp == 4'd1) || (MDUOp == 4'd3) || (MDUOp == 4'd7);
    start_eff = start & ~req & (state == IDLE) & (is_mul | is_div);
    busy      = start_eff | (state == BUSY);
    div0      = (B == '0);

    if (is_sgn) prod = 64'($signed(A)) * 64'($signed(B));
    else        prod = {32'b0, A} * {32'b0, B};

    // Divide on magnitudes so 0x80000000 / -1 has a well-defined wrap.
    abs_a = (is_sgn && A[31]) ? -A : A;
    abs_b = (is_sgn && B[31]) ? -B : B;
    q_mag = div0 ? '0 : abs_a / abs_b;
    r_mag = div0 ? '0 : abs_a % abs_b;
    quot  = (is_sgn && (A[31] ^ B[31])) ? -q_mag : q_mag;
    rem   = (is_sgn && A[31]) ? -r_mag : r_mag;

    if (is_div)       res = {rem, quot};
    else if (is_madd) res = {HI, LO} + prod;
    else              res = prod;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
      rhi   <= '0;
      rlo   <= '0;
      rwr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_eff) begin
            {rhi, rlo} <= res;
            rwr        <= ~(is_div & div0);
            cnt        <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state      <= BUSY;
          end else if (~req && MDUOp == 4'd5) begin
            HI <= A;
          end else if (~req && MDUOp == 4'd6) begin
            LO <= A;
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            if (rwr) begin
              HI <= rhi;
              LO <= rlo;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_core.sv
// Scoreboard bench for mdu_core: driver pushes expected busy length and HI/LO,
// monitor pops when a result is presented.
module tb_mdu_core;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  MDUOp = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] HI, LO;

  mdu_core #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          txn = 0;
  logic        chk = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check32(input string name, input int id, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s txn %0d: got %h expected %h", name, id, act, req_v);
    end
  endtask

  // Monitor: a result is presented on the first non-busy cycle after a busy run,
  // or on a driver strobe for operations that never raise busy.
  initial begin
    int run = 0;
    int id = 0;
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        run++;
      end else if (run > 0 || chk) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got busy run %0d expected no result", run);
        end else begin
          e = exp_q.pop_front();
          check32("busy_len", id, 32'(run), 32'(e.len));
          check32("HI", id, HI, e.hi);
          check32("LO", id, LO, e.lo);
        end
        id++;
        run = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy === 1'b1 && n < 64);
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy after %0d cycles expected idle", n);
    end
    @(posedge clk); #1;
  endtask

  // Reference: apply the architectural effect of one instruction to the model.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic r);
    exp_t e;
    logic started;
    longint sa, sb, q, rm;
    longint unsigned p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    started = !r && ((op >= 4'd1 && op <= 4'd4) || (MADD_EN && (op == 4'd7 || op == 4'd8)));
    e.op = op;
    e.len = started ? ((op == 4'd3 || op == 4'd4) ? 8'(DIV_N + 1) : 8'(MULT_N + 1)) : 8'd0;
    if (started) begin
      case (op)
        4'd1, 4'd7: p = longint'(sa * sb);
        4'd2, 4'd8: p = {32'b0, a} * {32'b0, b};
        default:    p = 0;
      endcase
      acc = {m_hi, m_lo};
      if (op == 4'd1 || op == 4'd2) {m_hi, m_lo} = p;
      else if (op == 4'd7 || op == 4'd8) {m_hi, m_lo} = acc + p;
      else if (b != 0) begin
        if (op == 4'd3) begin
          q = sa / sb;
          rm = sa % sb;
        end else begin
          q = longint'({32'b0, a} / {32'b0, b});
          rm = longint'({32'b0, a} % {32'b0, b});
        end
        m_lo = q[31:0];
        m_hi = rm[31:0];
      end
    end else if (!r && op == 4'd5) begin
      m_hi = a;
    end else if (!r && op == 4'd6) begin
      m_lo = a;
    end
    e.hi = m_hi;
    e.lo = m_lo;
    exp_q.push_back(e);
    txn++;

    start = !(op == 4'd5 || op == 4'd6);
    MDUOp = op;
    A = a;
    B = b;
    req = r;
    @(posedge clk); #1;
    start = 1'b0;
    MDUOp = '0;
    req = 1'b0;
    A = $urandom;
    B = $urandom;
    if (e.len == 0) begin
      chk = 1'b1;
      @(posedge clk); #1;
      chk = 1'b0;
    end else begin
      wait_idle();
    end
  endtask

  // Reset arrives while a div is at cnt==4: busy ran start cycle plus cnt 10..4.
  task automatic reset_mid(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    m_hi = '0;
    m_lo = '0;
    e.op = 4'd3;
    e.len = 8'(DIV_N - 4 + 2);
    e.hi = '0;
    e.lo = '0;
    exp_q.push_back(e);
    start = 1'b1;
    MDUOp = 4'd3;
    A = a;
    B = b;
    @(posedge clk); #1;
    start = 1'b0;
    MDUOp = '0;
    repeat (DIV_N - 4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    logic [3:0]  op;
    logic [31:0] a, b;
    e = '0;
    exp_q.push_back(e);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk = 1'b1;
    @(posedge clk); #1;
    chk = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(4'd4, 32'd7, 32'd0, 1'b0);
    issue(4'd3, 32'd100, 32'd0, 1'b0);
    issue(4'd5, 32'h1234, 32'd0, 1'b0);
    issue(4'd5, 32'h5678, 32'd0, 1'b1);
    issue(4'd6, 32'hABCD, 32'd0, 1'b1);
    issue(4'd3, 32'd50, 32'd7, 1'b1);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
    issue(4'd4, 32'hFFFF_FFFF, 32'd16, 1'b0);
    reset_mid(32'd1000, 32'd3);
    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(4'd7, 32'd1, 32'd1, 1'b0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(4'd0, 32'd9, 32'd9, 1'b0);
    issue(4'd9, 32'd9, 32'd9, 1'b0);
    issue(4'd15, 32'd9, 32'd9, 1'b0);

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 10));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      issue(op, a, b, ($urandom_range(0, 5) == 0));
    end

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
